// File: rtl/mem_stage_hs_pkg.sv
// Shared types for the MEM stage: access size, branch condition and FSM state,
// plus the alignment and branch-condition helpers used by the stage.
package mem_stage_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE  = 2'd0,
      SZ_HALF  = 2'd1,
      SZ_WORD  = 2'd2,
      SZ_WORD3 = 2'd3   // unused encoding, behaves as a word access
   } size_e;

   typedef enum logic [2:0] {
      BR_GTZ  = 3'd0,
      BR_EQ   = 3'd1,
      BR_NE   = 3'd2,
      BR_LTZ  = 3'd3,
      BR_GEZ  = 3'd4,
      BR_LEZ  = 3'd5,
      BR_RSV6 = 3'd6,
      BR_RSV7 = 3'd7
   } br_cond_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Half accesses need an even address, word accesses a multiple of four.
   function automatic logic addr_fault(input size_e sz, input logic [1:0] lane);
      case (sz)
         SZ_BYTE: addr_fault = 1'b0;
         SZ_HALF: addr_fault = lane[0];
         default: addr_fault = (lane != 2'b00);
      endcase
   endfunction

   // GTZ keeps the legacy "positive" test on the zero/negative flags.
   function automatic logic branch_taken(input br_cond_e cond, input logic zero,
                                         input logic neg);
      case (cond)
         BR_GTZ:  branch_taken = ~zero & ~neg;
         BR_EQ:   branch_taken = zero;
         BR_NE:   branch_taken = ~zero;
         BR_LTZ:  branch_taken = neg;
         BR_GEZ:  branch_taken = ~neg;
         BR_LEZ:  branch_taken = zero | neg;
         default: branch_taken = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mem_stage_hs_lane_align.sv
// Byte-lane helper: byte enables and replicated store data for a sub-word
// store, and lane extraction with sign/zero extension for a sub-word load.
module mem_lane_align
   import mem_stage_pkg::*;
#(
   parameter  int unsigned DATA_W = 32,
   localparam int unsigned BE_W   = DATA_W / 8
) (
   input  logic [1:0]        size,
   input  logic [1:0]        lane,
   input  logic [DATA_W-1:0] store_data,
   input  logic [DATA_W-1:0] load_data,
   input  logic              load_unsigned,
   output logic [BE_W-1:0]   be,
   output logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] load_ext
);

   size_e             sz;
   logic [DATA_W-1:0] shifted;

   assign sz = size_e'(size);

   // Store side: enables cover the addressed lanes, data is copied to every lane
   always_comb begin
      be    = '1;
      wdata = store_data;
      case (sz)
         SZ_BYTE: begin
            be = BE_W'(1) << lane;
            for (int unsigned i = 0; i < BE_W; i++) wdata[i*8 +: 8] = store_data[7:0];
         end
         SZ_HALF: begin
            be = BE_W'(3) << lane;
            for (int unsigned i = 0; i < BE_W; i++) wdata[i*8 +: 8] = store_data[(i%2)*8 +: 8];
         end
         default: ;
      endcase
   end

   // Load side: addressed lane moved down to bit 0, then extended
   always_comb begin
      shifted  = load_data >> {lane, 3'b000};
      load_ext = shifted;
      case (sz)
         SZ_BYTE: load_ext = {{(DATA_W-8){~load_unsigned & shifted[7]}}, shifted[7:0]};
         SZ_HALF: load_ext = {{(DATA_W-16){~load_unsigned & shifted[15]}}, shifted[15:0]};
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_stage_hs.sv
// Pipeline MEM stage with a req/ready data-memory handshake, byte-lane
// stores, extended loads, selectable branch condition and stall back-pressure.
module mem_stage_hs
   import mem_stage_pkg::*;
#(
   parameter  int unsigned DATA_W   = 32,
   parameter  int unsigned ADDR_W   = 11,
   parameter  int unsigned MAX_WAIT = 15,
   localparam int unsigned BE_W     = DATA_W / 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] alu_result,
   input  logic [DATA_W-1:0] store_data,
   input  logic              mem_write,
   input  logic              mem_read,
   input  logic              branch,
   input  logic [2:0]        br_cond,
   input  logic [1:0]        size,
   input  logic              load_unsigned,
   input  logic              zero_mem,
   input  logic              negative_mem,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [BE_W-1:0]   dmem_be,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic [DATA_W-1:0] dmem_rdata,
   input  logic              dmem_ready,
   output logic [DATA_W-1:0] read_data,
   output logic [DATA_W-1:0] reg_data,
   output logic              branch_sel,
   output logic              out_valid,
   output logic              stall,
   output logic              misaligned,
   output logic              timeout
);

   localparam int unsigned     CNT_W   = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

   state_e            state;
   logic [CNT_W-1:0]  wait_cnt;

   // Context of the instruction whose memory access is in flight
   logic              p_load;
   logic [1:0]        p_size;
   logic [1:0]        p_lane;
   logic              p_unsigned;
   logic [DATA_W-1:0] p_result;
   logic              p_branch;

   logic [1:0]        lane;
   logic              mem_op;
   logic              fault;
   logic              take;
   logic              accept;
   logic              take_br;
   logic [1:0]        al_size;
   logic [1:0]        al_lane;
   logic              al_unsigned;
   logic [BE_W-1:0]   al_be;
   logic [DATA_W-1:0] al_wdata;
   logic [DATA_W-1:0] al_load;

   assign lane    = alu_result[1:0];
   assign mem_op  = mem_read | mem_write;
   assign fault   = mem_op & addr_fault(size_e'(size), lane);
   assign take    = in_valid & (state != REQ);
   assign accept  = take & mem_op & ~fault;
   assign take_br = branch & branch_taken(br_cond_e'(br_cond), zero_mem, negative_mem);

   assign stall    = (state == REQ) | accept;
   assign dmem_req = (state == REQ);

   // One lane aligner serves both directions: live inputs while accepting a
   // store, captured size/lane while the load response is arriving.
   assign al_size     = (state == REQ) ? p_size     : size;
   assign al_lane     = (state == REQ) ? p_lane     : lane;
   assign al_unsigned = (state == REQ) ? p_unsigned : load_unsigned;

   mem_lane_align #(.DATA_W(DATA_W)) u_align (
      .size          (al_size),
      .lane          (al_lane),
      .store_data    (store_data),
      .load_data     (dmem_rdata),
      .load_unsigned (al_unsigned),
      .be            (al_be),
      .wdata         (al_wdata),
      .load_ext      (al_load)
   );

   // Handshake FSM with registered results, wait counter and sticky timeout
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         wait_cnt   <= '0;
         timeout    <= 1'b0;
         out_valid  <= 1'b0;
         misaligned <= 1'b0;
         branch_sel <= 1'b0;
         read_data  <= '0;
         reg_data   <= '0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_be    <= '0;
         dmem_wdata <= '0;
         p_load     <= 1'b0;
         p_size     <= '0;
         p_lane     <= '0;
         p_unsigned <= 1'b0;
         p_result   <= '0;
         p_branch   <= 1'b0;
      end else begin
         out_valid  <= 1'b0;
         misaligned <= 1'b0;
         branch_sel <= 1'b0;
         case (state)
            IDLE, DONE: begin
               state <= IDLE;
               if (accept) begin
                  state      <= REQ;
                  wait_cnt   <= '0;
                  dmem_we    <= mem_write;
                  dmem_addr  <= {alu_result[ADDR_W-1:2], 2'b00};
                  dmem_be    <= mem_write ? al_be : '1;
                  dmem_wdata <= al_wdata;
                  p_load     <= ~mem_write;
                  p_size     <= size;
                  p_lane     <= lane;
                  p_unsigned <= load_unsigned;
                  p_result   <= alu_result;
                  p_branch   <= take_br;
               end else if (take) begin
                  out_valid  <= 1'b1;
                  misaligned <= fault;
                  branch_sel <= take_br & ~fault;
                  reg_data   <= alu_result;
                  read_data  <= '0;
               end
            end
            REQ: begin
               if (dmem_ready) begin
                  state      <= DONE;
                  out_valid  <= 1'b1;
                  branch_sel <= p_branch;
                  reg_data   <= p_result;
                  read_data  <= p_load ? al_load : '0;
               end else if (wait_cnt != CNT_MAX) begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
                  if (wait_cnt == CNT_W'(MAX_WAIT - 1)) timeout <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage_hs.sv
// Directed bench for mem_stage_hs: a transaction-level model predicts each
// result, the cycle it appears, and the stall/request activity per cycle.
module tb_mem_stage_hs;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic [31:0] alu_result;
   logic [31:0] store_data;
   logic        mem_write;
   logic        mem_read;
   logic        branch;
   logic [2:0]  br_cond;
   logic [1:0]  size;
   logic        load_unsigned;
   logic        zero_mem;
   logic        negative_mem;
   logic        dmem_req;
   logic        dmem_we;
   logic [10:0] dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic [31:0] dmem_rdata;
   logic        dmem_ready;
   logic [31:0] read_data;
   logic [31:0] reg_data;
   logic        branch_sel;
   logic        out_valid;
   logic        stall;
   logic        misaligned;
   logic        timeout;

   mem_stage_hs #(.DATA_W(32), .ADDR_W(11), .MAX_WAIT(15)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .alu_result(alu_result),
      .store_data(store_data), .mem_write(mem_write), .mem_read(mem_read),
      .branch(branch), .br_cond(br_cond), .size(size), .load_unsigned(load_unsigned),
      .zero_mem(zero_mem), .negative_mem(negative_mem), .dmem_req(dmem_req),
      .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
      .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
      .read_data(read_data), .reg_data(reg_data), .branch_sel(branch_sel),
      .out_valid(out_valid), .stall(stall), .misaligned(misaligned), .timeout(timeout)
   );

   always #5 clk = ~clk;

   localparam int NO_TMO = 1 << 30;

   typedef struct {
      int          cyc;
      logic [31:0] reg_data;
      bit          chk_rd;
      logic [31:0] rd;
      bit          br;
      bit          mis;
   } exp_t;

   exp_t        sb[$];
   exp_t        ce;
   bit          exp_ov;
   bit          exp_stall [4096];
   bit          exp_req   [4096];
   int          tmo_from = NO_TMO;
   bit          chk_en   = 1'b0;
   int          cyc      = 0;
   int          n_cmp    = 0;
   int          n_bad    = 0;
   int          last_acc;
   int          r0;
   int          s0;

   logic        xb_we;
   logic [10:0] xb_addr;
   logic [3:0]  xb_be;
   logic [31:0] xb_wdata;

   int          obs_ov_cyc;
   logic [31:0] obs_rd;
   bit          obs_mis;
   bit          obs_br;
   logic [3:0]  obs_be;
   logic [31:0] obs_wdata;
   logic [10:0] obs_addr;
   int          req_n = 0;
   int          stall_req_n = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, want);
      end
   endtask

   // ---------------- model ----------------
   function automatic bit m_fault(input logic [1:0] sz, input logic [31:0] a);
      if (sz == 2'd0) return 1'b0;
      if (sz == 2'd1) return a[0];
      return a[1:0] != 2'd0;
   endfunction

   function automatic bit m_branch(input logic [2:0] c, input bit z, input bit n);
      case (c)
         3'd0: return !z && !n;
         3'd1: return z;
         3'd2: return !z;
         3'd3: return n;
         3'd4: return !n;
         3'd5: return z || n;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [1:0] lane);
      if (sz == 2'd0) return 4'b0001 << lane;
      if (sz == 2'd1) return 4'b0011 << lane;
      return 4'b1111;
   endfunction

   function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] d);
      if (sz == 2'd0) return d[7:0] * 32'h0101_0101;
      if (sz == 2'd1) return d[15:0] * 32'h0001_0001;
      return d;
   endfunction

   function automatic logic [31:0] m_load(input logic [1:0] sz, input logic [1:0] lane,
                                          input logic [31:0] rd, input bit uns);
      logic [31:0] s;
      int          width;
      longint      v;
      s     = rd >> (8 * lane);
      width = (sz == 2'd0) ? 8 : (sz == 2'd1) ? 16 : 32;
      if (width == 32) return s;
      v = longint'(s) & ((longint'(1) << width) - 1);
      if (!uns && v >= (longint'(1) << (width - 1))) v = v - (longint'(1) << width);
      return v[31:0];
   endfunction

   // ---------------- stimulus ----------------
   task automatic issue(input bit wr, input bit rd, input logic [1:0] sz,
                        input logic [31:0] addr, input logic [31:0] sdata, input bit uns,
                        input bit br, input logic [2:0] cond, input bit z, input bit n,
                        input int waits, input logic [31:0] rdata);
      exp_t e;
      bit   memop;
      bit   flt;
      memop = wr || rd;
      flt   = memop && m_fault(sz, addr);
      in_valid = 1'b1; mem_write = wr; mem_read = rd; size = sz; alu_result = addr;
      store_data = sdata; load_unsigned = uns; branch = br; br_cond = cond;
      zero_mem = z; negative_mem = n; dmem_ready = 1'b0;
      last_acc   = cyc;
      e.reg_data = addr;
      e.mis      = flt;
      e.br       = br && m_branch(cond, z, n) && !flt;
      e.chk_rd   = flt || (rd && !wr);
      e.rd       = flt ? 32'h0 : m_load(sz, addr[1:0], rdata, uns);
      if (!memop || flt) begin
         e.cyc = last_acc + 1;
         sb.push_back(e);
         @(posedge clk); #1;
      end else begin
         e.cyc = last_acc + 2 + waits;
         sb.push_back(e);
         xb_we    = wr;
         xb_addr  = addr[10:0] & 11'h7FC;
         xb_be    = wr ? m_be(sz, addr[1:0]) : 4'hF;
         xb_wdata = m_wdata(sz, sdata);
         for (int k = last_acc; k <= last_acc + 1 + waits; k++) exp_stall[k] = 1'b1;
         for (int k = last_acc + 1; k <= last_acc + 1 + waits; k++) exp_req[k] = 1'b1;
         if (waits >= 15 && last_acc + 16 < tmo_from) tmo_from = last_acc + 16;
         @(posedge clk); #1;
         repeat (waits) begin @(posedge clk); #1; end
         dmem_ready = 1'b1; dmem_rdata = rdata;
         @(posedge clk); #1;
      end
      in_valid = 1'b0; dmem_ready = 1'b0; mem_read = 1'b0; mem_write = 1'b0; branch = 1'b0;
   endtask

   task automatic alu_op(input logic [31:0] a, input bit br, input logic [2:0] c,
                         input bit z, input bit n);
      issue(0, 0, 2'd0, a, 32'h0, 0, br, c, z, n, 0, 32'h0);
   endtask

   task automatic mem(input bit wr, input bit rd, input logic [1:0] sz, input logic [31:0] a,
                      input logic [31:0] sd, input bit uns, input int waits,
                      input logic [31:0] rdata);
      issue(wr, rd, sz, a, sd, uns, 0, 3'd0, 0, 0, waits, rdata);
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         exp_ov = (sb.size() > 0) && (sb[0].cyc == cyc);
         chk("out_valid", out_valid, exp_ov);
         if (exp_ov) begin
            ce = sb.pop_front();
            chk("reg_data", reg_data, ce.reg_data);
            chk("branch_sel", branch_sel, ce.br);
            chk("misaligned", misaligned, ce.mis);
            if (ce.chk_rd) chk("read_data", read_data, ce.rd);
         end
         chk("stall", stall, exp_stall[cyc % 4096]);
         chk("dmem_req", dmem_req, exp_req[cyc % 4096]);
         if (exp_req[cyc % 4096]) begin
            chk("dmem_we", dmem_we, xb_we);
            chk("dmem_addr", dmem_addr, xb_addr);
            chk("dmem_be", dmem_be, xb_be);
            chk("dmem_wdata", dmem_wdata, xb_wdata);
         end
         chk("timeout", timeout, cyc >= tmo_from);
      end
      if (out_valid) begin
         obs_ov_cyc = cyc; obs_rd = read_data; obs_mis = misaligned; obs_br = branch_sel;
      end
      if (dmem_req) begin
         obs_be = dmem_be; obs_wdata = dmem_wdata; obs_addr = dmem_addr;
         req_n++;
         if (stall) stall_req_n++;
      end
   end

   // ---------------- directed sequence ----------------
   initial begin
      reset = 1'b1; in_valid = 1'b0; alu_result = '0; store_data = '0; mem_write = 1'b0;
      mem_read = 1'b0; branch = 1'b0; br_cond = '0; size = '0; load_unsigned = 1'b0;
      zero_mem = 1'b0; negative_mem = 1'b0; dmem_rdata = '0; dmem_ready = 1'b0;
      idle(2);
      chk("rst_ctrl", {dmem_req, dmem_we, stall, out_valid, misaligned, timeout, branch_sel}, 0);
      chk("rst_reg_data", reg_data, 0);
      chk("rst_read_data", read_data, 0);
      chk("rst_bus", {dmem_addr, dmem_be, dmem_wdata}, 0);
      reset = 1'b0;
      chk_en = 1'b1;

      // Branch condition table over three flag patterns and codes 0..6
      for (int f = 0; f < 3; f++)
         for (int c = 0; c < 7; c++)
            alu_op(32'h1000 + 32'(f * 16 + c), 1, 3'(c), f == 1, f == 2);
      idle(1);
      chk("br_gtz_lit", obs_br, 0);  // last op: code 6 -> never taken

      // Store byte, zero-wait
      mem(1, 0, 2'd0, 32'h005, 32'h0000_00AB, 0, 0, 32'h0);
      idle(1);
      chk("sb_be", obs_be, 4'b0010);
      chk("sb_wdata", obs_wdata, 32'hABAB_ABAB);
      chk("sb_addr", obs_addr, 11'h004);
      chk("sb_latency", obs_ov_cyc - last_acc, 2);

      // Load byte with 3 wait states, signed then unsigned
      s0 = stall_req_n;
      mem(0, 1, 2'd0, 32'h007, 32'h0, 0, 3, 32'h80FF_0000);
      idle(1);
      chk("lb_signed", obs_rd, 32'hFFFF_FF80);
      chk("lb_stall_req_cycles", stall_req_n - s0, 4);
      chk("lb_latency", obs_ov_cyc - last_acc, 5);
      mem(0, 1, 2'd0, 32'h007, 32'h0, 1, 3, 32'h80FF_0000);
      idle(1);
      chk("lb_unsigned", obs_rd, 32'h0000_0080);

      // Back-to-back mixed accesses, each accepted in the previous DONE cycle
      mem(1, 0, 2'd1, 32'h00A, 32'h1234_BEEF, 0, 0, 32'h0);
      mem(0, 1, 2'd1, 32'h00E, 32'h0, 0, 0, 32'h8001_0000);
      mem(1, 0, 2'd2, 32'h010, 32'hDEAD_BEEF, 0, 1, 32'h0);
      mem(0, 1, 2'd2, 32'h014, 32'h0, 0, 2, 32'h1234_5678);
      mem(0, 1, 2'd0, 32'h7F9, 32'h0, 1, 0, 32'h0000_C300);
      mem(1, 1, 2'd3, 32'h018, 32'hCAFE_F00D, 0, 1, 32'h5555_5555);
      alu_op(32'h0000_0123, 1, 3'd4, 0, 0);
      mem(0, 1, 2'd1, 32'h012, 32'h0, 1, 0, 32'hFEDC_0000);
      idle(1);
      chk("lh_unsigned", obs_rd, 32'h0000_FEDC);

      // Misaligned accesses never reach memory
      r0 = req_n;
      issue(0, 1, 2'd2, 32'h002, 32'h0, 0, 1, 3'd1, 1, 0, 0, 32'hFFFF_FFFF);
      idle(1);
      chk("mis_flag", obs_mis, 1);
      chk("mis_read_data", obs_rd, 0);
      chk("mis_branch", obs_br, 0);
      mem(0, 1, 2'd1, 32'h001, 32'h0, 0, 0, 32'h0);
      mem(1, 0, 2'd1, 32'h003, 32'hFFFF, 0, 0, 32'h0);
      idle(1);
      chk("mis_no_req", req_n - r0, 0);

      // Timeout: ready held low 20 cycles, completes in the 21st
      mem(0, 1, 2'd2, 32'h020, 32'h0, 0, 20, 32'h0BAD_F00D);
      idle(1);
      chk("tmo_latency", obs_ov_cyc - last_acc, 22);
      chk("tmo_sticky", timeout, 1);
      alu_op(32'h0000_0456, 0, 3'd0, 0, 0);
      idle(1);

      // Reset while a load is waiting for memory
      chk_en = 1'b0;
      in_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; size = 2'd2;
      alu_result = 32'h040; dmem_ready = 1'b0;
      idle(3);
      chk("pre_rst_req", {dmem_req, stall, timeout}, 3'b111);
      reset = 1'b1; in_valid = 1'b0; mem_read = 1'b0;
      idle(1);
      chk("post_rst_req", dmem_req, 0);
      chk("post_rst_stall", stall, 0);
      chk("post_rst_timeout", timeout, 0);
      chk("post_rst_ctrl", {out_valid, misaligned, branch_sel, dmem_we}, 0);
      chk("post_rst_data", {reg_data, read_data}, 0);
      reset = 1'b0;
      tmo_from = NO_TMO;
      chk_en = 1'b1;

      alu_op(32'h0000_0789, 1, 3'd5, 1, 0);
      mem(0, 1, 2'd2, 32'h044, 32'h0, 0, 0, 32'h7654_3210);
      idle(2);
      chk("final_load", obs_rd, 32'h7654_3210);
      chk("sb_drained", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
